// File: rtl/dnn_sram_pkg.sv
// rtl/dnn_sram_pkg.sv - shared constants and types for the double-buffered SRAM
package dnn_sram_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_BANK_ADDR_WIDTH = 12;
    localparam int NUM_BANKS               = 2;

    // Index of one of the two ping-pong banks.
    typedef logic bank_sel_t;

endpackage

// File: rtl/double_buffer_sram_if.sv
// rtl/double_buffer_sram_if.sv - producer/consumer/switch bundle for double_buffer_sram
//
// Signals:
//   switch_banks            one-cycle pulse that swaps write and read banks
//   wen/wadr/wdata/wmask    write port into the current write bank
//   ren/radr                read launch from the current read bank
//   rdata/rvalid            read result, one cycle after launch; rdata held otherwise
//   wbank_sel               current write bank index (read bank is its complement)
// Modports:
//   master  the client (loader, feeder, sequencer) driving the buffer
//   slave   the buffer itself
interface double_buffer_sram_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int NUM_WMASKS      = DATA_WIDTH / 8
);

    logic                       switch_banks;
    logic                       wen;
    logic [BANK_ADDR_WIDTH-1:0] wadr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [NUM_WMASKS-1:0]      wmask;
    logic                       ren;
    logic [BANK_ADDR_WIDTH-1:0] radr;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       rvalid;
    logic                       wbank_sel;

    modport master (
        output switch_banks, wen, wadr, wdata, wmask, ren, radr,
        input  rdata, rvalid, wbank_sel
    );

    modport slave (
        input  switch_banks, wen, wadr, wdata, wmask, ren, radr,
        output rdata, rvalid, wbank_sel
    );

endinterface

// File: rtl/dual_port_sram_bank.sv
// rtl/dual_port_sram_bank.sv - one 1R1W SRAM bank with byte write mask
//
// Ports:
//   clk              bank clock
//   csb0/web0        write port chip select / write enable, both active low
//   wmask0           per-byte write enables, bit i covers din0[8i+7:8i]
//   addr0/din0       write address and data
//   csb1/addr1       read port chip select (active low) and address
//   dout1            read data, valid the cycle after a selected read
// Behavioural model of the macro; contents are never reset, and dout1 keeps its
// value while the read port is deselected.
module dual_port_sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout1_q;
    logic [DATA_WIDTH-1:0] dout1_d;

    always_comb begin
        dout1_d = dout1_q;
        if (!csb1) begin
            dout1_d = mem[addr1];
        end
    end

    always_ff @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end
        end
        dout1_q <= dout1_d;
    end

    assign dout1 = dout1_q;

endmodule

// File: rtl/double_buffer_sram.sv
// rtl/double_buffer_sram.sv - ping-pong buffer over two 1R1W SRAM banks
//
// Ports:
//   clk     single clock for both banks and control
//   rst_n   asynchronous active-low reset
//   bus     double_buffer_sram_if slave: write port, read launch, read result,
//           switch pulse and current write-bank index
// One bank is written while the other is read; a switch pulse swaps them.
module double_buffer_sram
    import dnn_sram_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int BANK_ADDR_WIDTH = DEFAULT_BANK_ADDR_WIDTH,
    parameter int NUM_WMASKS      = DATA_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    double_buffer_sram_if.slave  bus
);

    bank_sel_t             wbank_sel_q, wbank_sel_d;
    bank_sel_t             rd_bank_q,   rd_bank_d;
    logic                  rvalid_q,    rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;

    logic [NUM_BANKS-1:0]  csb0;
    logic [NUM_BANKS-1:0]  web0;
    logic [NUM_BANKS-1:0]  csb1;
    logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rdata_out;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dual_port_sram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BANK_ADDR_WIDTH),
            .NUM_WMASKS (NUM_WMASKS)
        ) u_bank (
            .clk    (clk),
            .csb0   (csb0[b]),
            .web0   (web0[b]),
            .wmask0 (bus.wmask),
            .addr0  (bus.wadr),
            .din0   (bus.wdata),
            .csb1   (csb1[b]),
            .addr1  (bus.radr),
            .dout1  (bank_dout[b])
        );
    end

    // Bank selects. Everything keys off the registered wbank_sel_q, so a write
    // or read on the same edge as a switch still uses the old roles. Idle banks
    // and banks under reset keep csb high.
    always_comb begin
        csb0 = '1;
        web0 = '1;
        csb1 = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            csb0[b] = ~(bus.wen & (wbank_sel_q == 1'(b)) & rst_n);
            web0[b] = ~bus.wen;
            csb1[b] = ~(bus.ren & (wbank_sel_q != 1'(b)) & rst_n);
        end
    end

    // The read result comes straight from the launching bank's output register
    // in the cycle after launch, chosen by the bank index captured at launch,
    // not by the live wbank_sel. Otherwise the last result is replayed from
    // the hold register, which also gives rdata=0 immediately under reset.
    always_comb begin
        rdata_out = rvalid_q ? bank_dout[rd_bank_q] : rdata_q;
    end

    always_comb begin
        wbank_sel_d = wbank_sel_q ^ bus.switch_banks;
        rd_bank_d   = bus.ren ? ~wbank_sel_q : rd_bank_q;
        rvalid_d    = bus.ren;
        rdata_d     = rdata_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_sel_q <= 1'b0;
            rd_bank_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wbank_sel_q <= wbank_sel_d;
            rd_bank_q   <= rd_bank_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.rdata     = rdata_out;
    assign bus.rvalid    = rvalid_q;
    assign bus.wbank_sel = wbank_sel_q;

endmodule

// File: tb/tb_double_buffer_sram.sv
// tb/tb_double_buffer_sram.sv - directed self-checking bench for double_buffer_sram
module tb_double_buffer_sram;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    double_buffer_sram_if #(.DATA_WIDTH(32),  .BANK_ADDR_WIDTH(12), .NUM_WMASKS(4))  bus_n ();
    double_buffer_sram_if #(.DATA_WIDTH(128), .BANK_ADDR_WIDTH(13), .NUM_WMASKS(16)) bus_w ();

    double_buffer_sram #(.DATA_WIDTH(32), .BANK_ADDR_WIDTH(12), .NUM_WMASKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    double_buffer_sram #(.DATA_WIDTH(128), .BANK_ADDR_WIDTH(13), .NUM_WMASKS(16)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_n.switch_banks = 1'b0;
        bus_n.wen = 1'b0;  bus_n.wadr = '0; bus_n.wdata = '0; bus_n.wmask = '0;
        bus_n.ren = 1'b0;  bus_n.radr = '0;
        bus_w.switch_banks = 1'b0;
        bus_w.wen = 1'b0;  bus_w.wadr = '0; bus_w.wdata = '0; bus_w.wmask = '0;
        bus_w.ren = 1'b0;  bus_w.radr = '0;
    endtask

    task automatic wr_n(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_n.wen = 1'b1; bus_n.wadr = a; bus_n.wdata = d; bus_n.wmask = m;
        cyc();
        idle();
    endtask

    task automatic switch_n();
        bus_n.switch_banks = 1'b1;
        cyc();
        idle();
    endtask

    task automatic rd_n(input logic [11:0] a);
        bus_n.ren = 1'b1; bus_n.radr = a;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus_n.rvalid !== 1'b0)        begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'h0)        begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus_n.rdata); end
        checks++; if (bus_n.wbank_sel !== 1'b0)     begin errors++; $display("FAIL reset_wbank_sel: got %b expected 0", bus_n.wbank_sel); end
        checks++; if (bus_w.rvalid !== 1'b0)        begin errors++; $display("FAIL reset_wide_rvalid: got %b expected 0", bus_w.rvalid); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_ping_pong();
        wr_n(12'd0, 32'haaaaaaaa, 4'hF);
        switch_n();
        bus_n.ren = 1'b1; bus_n.radr = 12'd0;
        cyc();
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL pp_rvalid: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'haaaaaaaa) begin errors++; $display("FAIL pp_rdata: got %h expected aaaaaaaa", bus_n.rdata); end
        checks++; if (bus_n.wbank_sel !== 1'b1)     begin errors++; $display("FAIL pp_wbank_sel: got %b expected 1", bus_n.wbank_sel); end
        idle();
        cyc();
    endtask

    task automatic test_byte_mask();
        // write bank is 1 here
        wr_n(12'd5, 32'h11223344, 4'hF);
        wr_n(12'd5, 32'hAABBCCDD, 4'b0101);
        wr_n(12'd5, 32'hFFFFFFFF, 4'b0000);
        switch_n();
        rd_n(12'd5);
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL mask_rvalid: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'h11BB33DD) begin errors++; $display("FAIL mask_rdata: got %h expected 11bb33dd", bus_n.rdata); end
        cyc();
    endtask

    task automatic test_simul_switch();
        // write bank is 0 here; move to 1 to seed bank 1
        switch_n();
        wr_n(12'd7, 32'hDEAD0007, 4'hF);
        switch_n();
        checks++; if (bus_n.wbank_sel !== 1'b0)     begin errors++; $display("FAIL sim_pre_wbank: got %b expected 0", bus_n.wbank_sel); end
        bus_n.ren = 1'b1; bus_n.radr = 12'd7;
        bus_n.switch_banks = 1'b1;
        bus_n.wen = 1'b1; bus_n.wadr = 12'd7; bus_n.wdata = 32'h0BAD0007; bus_n.wmask = 4'hF;
        cyc();
        idle();
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL sim_rvalid: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'hDEAD0007) begin errors++; $display("FAIL sim_rdata: got %h expected dead0007", bus_n.rdata); end
        checks++; if (bus_n.wbank_sel !== 1'b1)     begin errors++; $display("FAIL sim_wbank: got %b expected 1", bus_n.wbank_sel); end
        // read bank is now 0, which took the same-edge write
        rd_n(12'd7);
        checks++; if (bus_n.rdata !== 32'h0BAD0007) begin errors++; $display("FAIL sim_old_wbank: got %h expected 0bad0007", bus_n.rdata); end
        cyc();
    endtask

    task automatic test_hold_valid();
        // write bank is 1 here
        wr_n(12'd0, 32'h12345678, 4'hF);
        wr_n(12'd1, 32'hCAFEF00D, 4'hF);
        switch_n();
        rd_n(12'd0);
        checks++; if (bus_n.rdata !== 32'h12345678) begin errors++; $display("FAIL hold_first: got %h expected 12345678", bus_n.rdata); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (bus_n.rvalid !== 1'b0)        begin errors++; $display("FAIL hold_rvalid%0d: got %b expected 0", i, bus_n.rvalid); end
            checks++; if (bus_n.rdata !== 32'h12345678) begin errors++; $display("FAIL hold_rdata%0d: got %h expected 12345678", i, bus_n.rdata); end
        end
        bus_n.ren = 1'b1; bus_n.radr = 12'd1;
        cyc();
        bus_n.radr = 12'd0;
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL b2b_v0: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_d0: got %h expected cafef00d", bus_n.rdata); end
        cyc();
        idle();
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL b2b_v1: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_d1: got %h expected 12345678", bus_n.rdata); end
        cyc();
        checks++; if (bus_n.rvalid !== 1'b0)        begin errors++; $display("FAIL b2b_end: got %b expected 0", bus_n.rvalid); end
    endtask

    task automatic test_double_switch();
        // write bank is 0 here
        bus_n.switch_banks = 1'b1;
        cyc();
        checks++; if (bus_n.wbank_sel !== 1'b1)     begin errors++; $display("FAIL dsw_first: got %b expected 1", bus_n.wbank_sel); end
        cyc();
        idle();
        checks++; if (bus_n.wbank_sel !== 1'b0)     begin errors++; $display("FAIL dsw_second: got %b expected 0", bus_n.wbank_sel); end
    endtask

    task automatic test_param_sweep();
        logic [127:0] hi_val;
        logic [127:0] lo_val;
        hi_val = 128'h0123456789ABCDEF_FEDCBA9876543210;
        lo_val = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
        bus_w.wen = 1'b1; bus_w.wadr = 13'h0000; bus_w.wdata = lo_val; bus_w.wmask = 16'hFFFF;
        cyc();
        bus_w.wadr = 13'h1FFF; bus_w.wdata = hi_val;
        cyc();
        idle();
        bus_w.switch_banks = 1'b1;
        cyc();
        idle();
        bus_w.ren = 1'b1; bus_w.radr = 13'h1FFF;
        cyc();
        bus_w.radr = 13'h0000;
        checks++; if (bus_w.rvalid !== 1'b1)        begin errors++; $display("FAIL wide_rvalid: got %b expected 1", bus_w.rvalid); end
        checks++; if (bus_w.rdata !== hi_val)       begin errors++; $display("FAIL wide_last: got %h expected %h", bus_w.rdata, hi_val); end
        cyc();
        idle();
        checks++; if (bus_w.rdata !== lo_val)       begin errors++; $display("FAIL wide_adr0: got %h expected %h", bus_w.rdata, lo_val); end
        cyc();
    endtask

    task automatic test_reset_mid();
        switch_n();
        bus_n.ren = 1'b1; bus_n.radr = 12'd0;  // read bank 0 adr 0 = aaaaaaaa
        cyc();
        idle();
        checks++; if (bus_n.rvalid !== 1'b1)        begin errors++; $display("FAIL mid_pre_rvalid: got %b expected 1", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'haaaaaaaa) begin errors++; $display("FAIL mid_pre_rdata: got %h expected aaaaaaaa", bus_n.rdata); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus_n.rvalid !== 1'b0)        begin errors++; $display("FAIL mid_rvalid: got %b expected 0", bus_n.rvalid); end
        checks++; if (bus_n.rdata !== 32'h0)        begin errors++; $display("FAIL mid_rdata: got %h expected 00000000", bus_n.rdata); end
        checks++; if (bus_n.wbank_sel !== 1'b0)     begin errors++; $display("FAIL mid_wbank: got %b expected 0", bus_n.wbank_sel); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_ping_pong();
        test_byte_mask();
        test_simul_switch();
        test_hold_valid();
        test_double_switch();
        test_param_sweep();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/double_buffer_sram.md
Name: double_buffer_sram

Overview:
- Parametrised ping-pong buffer built from two 1R1W SRAM banks. It is the successor to the single sram_4096_128 macro usage.
- One bank is the write bank, filled by the producer (e.g. weight/ifmap loader). The other is the read bank, drained by the consumer (PE array feeder).
- A single-cycle switch pulse swaps the roles of the two banks.
- Adds per-byte write masks, registered read-valid tracking and held read data, none of which the bare macro provides.

Parameters:
- DATA_WIDTH, 32, read/write word width in bits; must be a multiple of 8.
- BANK_ADDR_WIDTH, 12, address bits per bank; depth = 2**BANK_ADDR_WIDTH.
- NUM_WMASKS, DATA_WIDTH/8, number of byte write-mask bits.

Ports:
- clk  input  1  single clock for both banks and all control.
- rst_n  input  1  asynchronous, active-low reset.
- switch_banks  input  1  one-cycle pulse; swaps write and read banks.
- wen  input  1  active-high write enable.
- wadr  input  BANK_ADDR_WIDTH  write address within the current write bank.
- wdata  input  DATA_WIDTH  write data.
- wmask  input  NUM_WMASKS  byte enables; bit i covers wdata[8i+7:8i].
- ren  input  1  active-high read enable.
- radr  input  BANK_ADDR_WIDTH  read address within the current read bank.
- rdata  output  DATA_WIDTH  read data, registered.
- rvalid  output  1  high for the single cycle in which rdata carries a new read result.
- wbank_sel  output  1  index of the current write bank; the read bank is ~wbank_sel.

Behaviour:
- Reset (async assert, rst_n low):
  - wbank_sel=0, so bank 0 is written and bank 1 is read.
  - rvalid=0, rdata=0, read-bank capture register=1.
  - Both bank csb lines are forced high (deselected) while rst_n is low.
  - SRAM contents are not reset.
- Reset release is synchronous to clk. Operations are honoured from the first rising edge with rst_n high.
- Write:
  - On a rising edge with wen=1, bank[wbank_sel][wadr] is written for every byte whose wmask bit is 1.
  - Bytes with mask bit 0 keep their old value. wmask=0 with wen=1 is a no-op.
- Read:
  - On a rising edge with ren=1, bank[~wbank_sel][radr] is launched.
  - rdata updates and rvalid=1 exactly one cycle later (latency 1).
  - With no read launched in the prior cycle, rvalid=0 and rdata holds its last value.
- Read pipeline:
  - The bank index used by each read is captured at launch.
  - The data mux selects on the captured index, never on the live wbank_sel.
- Switch:
  - On a rising edge with switch_banks=1, wbank_sel toggles. The new value applies to operations launched from the next edge onward.
- Simultaneous events:
  - wen together with switch_banks: the write goes to the old write bank.
  - ren together with switch_banks: the read comes from the old read bank, and its data returns the next cycle from that bank.
  - Back-to-back switch pulses each toggle, so two consecutive pulses restore the original roles.
- Bank conflicts: the write bank never equals the read bank, so no same-bank read/write conflict can occur. No bypass path is required.
- Address wrap: addresses are exactly BANK_ADDR_WIDTH bits. There is no auto-increment and no out-of-range condition.
- Reset mid-operation:
  - An in-flight read is dropped: rvalid=0 and rdata=0 immediately on rst_n assertion.
  - A write on the same edge as reset assertion is not guaranteed.
- Macro interface:
  - Each bank's write port: csb0=~(wen & sel), web0=~wen, wmask0=wmask.
  - Each bank's read port: csb1=~(ren & sel), addr1=radr.
  - Idle banks hold csb high to save power.

Decomposition:
- Shared package dnn_sram_pkg:
  - DATA_WIDTH and BANK_ADDR_WIDTH defaults.
  - NUM_BANKS=2 constant.
  - typedef bank_sel_t (1 bit).
- Sub-module dual_port_sram_bank:
  - Wraps one 1R1W macro: active-low csb/web, wmask, 1-cycle read latency.
  - Instantiated twice.
  - Has a behavioural model for simulation and maps to the sram macro for synthesis.
- Top level holds the bank-select register, the captured read-bank register, the rvalid register, the rdata hold register and the output mux.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> rvalid=0, rdata=0, wbank_sel=0 immediately, without waiting for a clock edge.
- Basic ping-pong:
  - Write wadr=0, wdata=32'haaaaaaaa, wmask=4'hF, then pulse switch_banks.
  - Then ren=1, radr=0 -> one cycle later rvalid=1, rdata=32'haaaaaaaa, wbank_sel=1.
- Byte mask:
  - Write 32'h11223344 at adr 5 with mask F, then write 32'hAABBCCDD at adr 5 with mask 4'b0101, then switch and read adr 5.
  - Required: rdata=32'h11BB33DD.
- Simultaneous switch:
  - Bank 1 adr 7 holds 32'hDEAD0007. ren=1 at radr=7 on the same edge as switch_banks=1.
  - Required: rdata=32'hDEAD0007 next cycle.
  - The same-edge wen, with wdata=32'h0BAD0007 at wadr=7, lands in bank 0. A read of adr 7 issued after the next switch returns 32'h0BAD0007.
- Hold and valid:
  - Read returns 32'h12345678; ren stays 0 for 3 cycles.
  - Required: rvalid low for those cycles and rdata stays 32'h12345678.
  - Back-to-back reads at adr 0 and adr 1 -> rvalid high for 2 consecutive cycles with the data in order.
- Parameter sweep: DATA_WIDTH=128, BANK_ADDR_WIDTH=13, NUM_WMASKS=16.
  - Write at the last address 13'h1FFF, switch, read back.
  - Required: exact match, and no alias at address 0.
